load_store_unit: RTL and testbench

Memory-access stage directly downstream of the ALU in the RV32I core. It takes the ALU result as the effective address plus rs2 data for stores, and runs a request/acknowledge transaction to data memory. It handles byte-lane steering and load sign/zero extension, and returns a result for the register-file write-back mux. While a transaction is in flight it stalls the PC through `stall`.

---
 rtl/lsu_pkg.sv | 39 +++
 rtl/lsu_align.sv | 77 +++++++
 rtl/load_store_unit.sv | 171 +++++++++++++++++
 tb/tb_load_store_unit.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 and opcode encodings,
// FSM states, byte-enable base patterns and the memory command payload.
package lsu_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;

  localparam logic [3:0] BE_B = 4'b0001;
  localparam logic [3:0] BE_H = 4'b0011;
  localparam logic [3:0] BE_W = 4'b1111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_RESP = 2'd2
  } state_e;

  typedef struct packed {
    logic            we;
    logic [3:0]      be;
    logic [XLEN-1:0] wdata;
  } mem_cmd_t;

  // Stores accept only B/H/W; loads additionally accept the unsigned B/H forms.
  function automatic logic f3_legal(input logic we, input logic [2:0] f3);
    if (we) return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
           (f3 == F3_BU) || (f3 == F3_HU);
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane steering for the LSU: legality, store byte enables and
// replication, and load extraction/extension. Honors LSU_MISALIGNED_TRAP_EN.
module lsu_align
  import lsu_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic              we_i,
  input  logic [2:0]        funct3_i,
  input  logic [1:0]        addr_lo_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [2:0]        ld_funct3_i,
  input  logic [1:0]        ld_off_i,
  input  logic [DATA_W-1:0] rdata_i,
  output logic              illegal_o,
  output logic [1:0]        addr_lo_o,
  output logic [3:0]        be_o,
  output logic [DATA_W-1:0] wdata_o,
  output logic [DATA_W-1:0] rdata_o
);

  logic              misalign;
  logic [DATA_W-1:0] shifted;

  // Request side: legality, effective low address bits, store lanes.
  always_comb begin
    misalign  = 1'b0;
    addr_lo_o = addr_lo_i;
    be_o      = BE_W;
    wdata_o   = wdata_i;

    unique case (funct3_i[1:0])
      2'b01:   misalign = addr_lo_i[0];
      2'b10:   misalign = (addr_lo_i != 2'b00);
      default: misalign = 1'b0;
    endcase

`ifdef LSU_MISALIGNED_TRAP_EN
    illegal_o = !f3_legal(we_i, funct3_i) || misalign;
`else
    illegal_o = !f3_legal(we_i, funct3_i);
    if (misalign) begin
      addr_lo_o = (funct3_i[1:0] == 2'b01) ? {addr_lo_i[1], 1'b0} : 2'b00;
    end
`endif

    if (we_i) begin
      unique case (funct3_i[1:0])
        2'b00: begin
          be_o    = BE_B << addr_lo_o;
          wdata_o = DATA_W'({4{wdata_i[7:0]}});
        end
        2'b01: begin
          be_o    = BE_H << addr_lo_o;
          wdata_o = DATA_W'({2{wdata_i[15:0]}});
        end
        default: begin
          be_o    = BE_W;
          wdata_o = wdata_i;
        end
      endcase
    end
  end

  // Response side: shift the read word by the registered offset, then extend.
  always_comb begin
    shifted = rdata_i >> {ld_off_i, 3'b000};
    unique case (ld_funct3_i)
      F3_B:    rdata_o = {{(DATA_W-8){shifted[7]}}, shifted[7:0]};
      F3_H:    rdata_o = {{(DATA_W-16){shifted[15]}}, shifted[15:0]};
      F3_BU:   rdata_o = {{(DATA_W-8){1'b0}}, shifted[7:0]};
      F3_HU:   rdata_o = {{(DATA_W-16){1'b0}}, shifted[15:0]};
      default: rdata_o = shifted;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit: request/ack data-memory transaction with timeout.
// Build option LSU_MISALIGNED_TRAP_EN makes misaligned accesses fault.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic              stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              req_ready_q, req_ready_d;
  logic              stall_q, stall_d;
  logic              resp_valid_q, resp_valid_d;
  logic [DATA_W-1:0] resp_rdata_q, resp_rdata_d;
  logic              resp_err_q, resp_err_d;
  logic              mem_req_q, mem_req_d;
  mem_cmd_t          mem_cmd_q, mem_cmd_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [2:0]        ld_f3_q, ld_f3_d;
  logic [1:0]        ld_off_q, ld_off_d;

  logic              illegal_c;
  logic [1:0]        addr_lo_c;
  logic [3:0]        be_c;
  logic [DATA_W-1:0] wdata_c;
  logic [DATA_W-1:0] ld_data_c;

  lsu_align #(
    .DATA_W (DATA_W)
  ) u_align (
    .we_i        (req_we),
    .funct3_i    (req_funct3),
    .addr_lo_i   (req_addr[1:0]),
    .wdata_i     (req_wdata),
    .ld_funct3_i (ld_f3_q),
    .ld_off_i    (ld_off_q),
    .rdata_i     (mem_rdata),
    .illegal_o   (illegal_c),
    .addr_lo_o   (addr_lo_c),
    .be_o        (be_c),
    .wdata_o     (wdata_c),
    .rdata_o     (ld_data_c)
  );

  // Next-state and registered-output logic.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    resp_valid_d = 1'b0;
    resp_rdata_d = '0;
    resp_err_d   = 1'b0;
    mem_req_d    = mem_req_q;
    mem_cmd_d    = mem_cmd_q;
    mem_addr_d   = mem_addr_q;
    ld_f3_d      = ld_f3_q;
    ld_off_d     = ld_off_q;

    unique case (state_q)
      S_IDLE: begin
        if (req_valid && req_ready_q) begin
          if (illegal_c) begin
            state_d      = S_RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
          end else begin
            state_d         = S_BUSY;
            cnt_d           = '0;
            mem_req_d       = 1'b1;
            mem_cmd_d.we    = req_we;
            mem_cmd_d.be    = req_we ? be_c : BE_W;
            mem_cmd_d.wdata = wdata_c;
            mem_addr_d      = {req_addr[ADDR_W-1:2], 2'b00};
            ld_f3_d         = req_funct3;
            ld_off_d        = addr_lo_c;
          end
        end
      end
      S_BUSY: begin
        // An ack in the final allowed cycle still beats the timeout.
        if (mem_ack) begin
          state_d      = S_RESP;
          mem_req_d    = 1'b0;
          resp_valid_d = 1'b1;
          resp_rdata_d = mem_cmd_q.we ? '0 : ld_data_c;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
          state_d      = S_RESP;
          cnt_d        = CNT_W'(cnt_q + 1'b1);
          mem_req_d    = 1'b0;
          resp_valid_d = 1'b1;
          resp_err_d   = 1'b1;
        end else begin
          cnt_d = CNT_W'(cnt_q + 1'b1);
        end
      end
      S_RESP: state_d = S_IDLE;
      default: begin
        state_d   = S_IDLE;
        mem_req_d = 1'b0;
      end
    endcase

    req_ready_d = (state_d == S_IDLE);
    stall_d     = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      req_ready_q  <= 1'b1;
      stall_q      <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
      mem_req_q    <= 1'b0;
      mem_cmd_q    <= '0;
      mem_addr_q   <= '0;
      ld_f3_q      <= F3_B;
      ld_off_q     <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      req_ready_q  <= req_ready_d;
      stall_q      <= stall_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
      mem_req_q    <= mem_req_d;
      mem_cmd_q    <= mem_cmd_d;
      mem_addr_q   <= mem_addr_d;
      ld_f3_q      <= ld_f3_d;
      ld_off_q     <= ld_off_d;
    end
  end

  assign req_ready  = req_ready_q;
  assign stall      = stall_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;
  assign mem_req    = mem_req_q;
  assign mem_we     = mem_cmd_q.we;
  assign mem_addr   = mem_addr_q;
  assign mem_be     = mem_cmd_q.be;
  assign mem_wdata  = mem_cmd_q.wdata;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed vector table, reset/ack corner sequence,
// and random accesses checked against a byte-level reference model.
`timescale 1ns/1ps
module tb_load_store_unit;
  import lsu_pkg::*;

  localparam int unsigned ADDR_W      = 32;
  localparam int unsigned DATA_W      = 32;
  localparam int unsigned TIMEOUT_CYC = 16;
  localparam int          TMO         = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              req_valid, req_ready, req_we;
  logic [2:0]        req_funct3;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              resp_valid, resp_err, stall;
  logic [DATA_W-1:0] resp_rdata;
  logic              mem_req, mem_we, mem_ack;
  logic [ADDR_W-1:0] mem_addr;
  logic [3:0]        mem_be;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;

  int checks = 0;
  int errors = 0;

  load_store_unit #(
    .ADDR_W      (ADDR_W),
    .DATA_W      (DATA_W),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .stall      (stall),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_be     (mem_be),
    .mem_wdata  (mem_wdata),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          ack_lat;
    logic        exp_err;
    int          exp_busy;
    logic [31:0] exp_addr;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t tbl[14];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [6:0] opc, input logic [2:0] f3,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [31:0] rdata, input int lat,
                              input logic err, input int busy,
                              input logic [31:0] eaddr, input logic [3:0] ebe,
                              input logic [31:0] ewdata, input logic [31:0] erdata);
    vec_t v;
    v.opc = opc; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.rdata = rdata;
    v.ack_lat = lat; v.exp_err = err; v.exp_busy = busy; v.exp_addr = eaddr;
    v.exp_be = ebe; v.exp_wdata = ewdata; v.exp_rdata = erdata;
    return v;
  endfunction

  // Reference model: access size in bytes, offset within the word, byte replication.
  function automatic vec_t model(input vec_t v);
    vec_t        r;
    bit          we, legal;
    int          a, size, off;
    logic [31:0] word, mask;
    r = v;
    we = (v.opc == OPC_STORE);
    a = int'(v.addr[1:0]);
    legal = we ? (v.f3 <= 3'd2) : (v.f3 != 3'd3 && v.f3 != 3'd6 && v.f3 != 3'd7);
    size = 1 << v.f3[1:0];
`ifdef LSU_MISALIGNED_TRAP_EN
    if (legal && (a % size) != 0) legal = 0;
`endif
    off = (a / size) * size;
    r.exp_addr  = v.addr & ~32'h3;
    r.exp_wdata = 32'h0;
    r.exp_be    = 4'hF;
    if (!legal) begin
      r.exp_err = 1'b1; r.exp_busy = 0; r.exp_rdata = 32'h0;
      return r;
    end
    r.exp_err  = (v.ack_lat >= TMO);
    r.exp_busy = (v.ack_lat >= TMO) ? TMO : v.ack_lat + 1;
    r.exp_rdata = 32'h0;
    if (we) begin
      r.exp_be = 4'(((1 << size) - 1) << off);
      for (int i = 0; i < 4; i++) r.exp_wdata[8*i +: 8] = v.wdata[8*(i % size) +: 8];
    end else if (!r.exp_err) begin
      mask = (size == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8*size)) - 32'h1);
      word = (v.rdata >> (8*off)) & mask;
      if (!v.f3[2] && size < 4 && word[8*size-1]) word = word | ~mask;
      r.exp_rdata = word;
    end
    return r;
  endfunction

  // Issue one access at a falling edge and follow it through to IDLE.
  task automatic run_vec(input vec_t v, input string nm);
    int   n;
    logic we;
    we = (v.opc == OPC_STORE);
    chk({nm, ".ready"}, 32'(req_ready), 32'h1);
    req_valid = 1'b1; req_we = we; req_funct3 = v.f3;
    req_addr = v.addr; req_wdata = v.wdata;
    @(negedge clk);
    req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom;
    n = 0;
    while (mem_req === 1'b1 && n < 40) begin
      n++;
      chk({nm, ".addr"}, mem_addr, v.exp_addr);
      chk({nm, ".be"}, 32'(mem_be), 32'(v.exp_be));
      chk({nm, ".stall"}, 32'(stall), 32'h1);
      if (n == 1) begin
        chk({nm, ".we"}, 32'(mem_we), 32'(we));
        if (we) chk({nm, ".wdata"}, mem_wdata, v.exp_wdata);
      end
      mem_ack   = (n - 1 == v.ack_lat);
      mem_rdata = mem_ack ? v.rdata : $urandom;
      @(negedge clk);
      mem_ack = 1'b0;
    end
    chk({nm, ".busy_len"}, 32'(n), 32'(v.exp_busy));
    chk({nm, ".resp_valid"}, 32'(resp_valid), 32'h1);
    chk({nm, ".resp_err"}, 32'(resp_err), 32'(v.exp_err));
    chk({nm, ".resp_rdata"}, resp_rdata, v.exp_rdata);
    chk({nm, ".resp_stall"}, 32'(stall), 32'h1);
    chk({nm, ".req_drop"}, 32'(mem_req), 32'h0);
    @(negedge clk);
    chk({nm, ".resp_once"}, 32'(resp_valid), 32'h0);
    chk({nm, ".idle_stall"}, 32'(stall), 32'h0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b0;
    req_addr = '0; req_wdata = '0; mem_ack = 1'b0; mem_rdata = '0;

    tbl[0]  = mk(OPC_STORE, F3_W,  32'h100, 32'hDEADBEEF, 32'h0, 1,  1'b0, 2,  32'h100, 4'hF, 32'hDEADBEEF, 32'h0);
    tbl[1]  = mk(OPC_LOAD,  F3_B,  32'h103, 32'h0, 32'h80000000, 0,  1'b0, 1,  32'h100, 4'hF, 32'h0, 32'hFFFFFF80);
    tbl[2]  = mk(OPC_LOAD,  F3_BU, 32'h103, 32'h0, 32'h80000000, 2,  1'b0, 3,  32'h100, 4'hF, 32'h0, 32'h00000080);
    tbl[3]  = mk(OPC_STORE, F3_H,  32'h102, 32'h0000ABCD, 32'h0, 0,  1'b0, 1,  32'h100, 4'hC, 32'hABCDABCD, 32'h0);
    tbl[4]  = mk(OPC_LOAD,  F3_HU, 32'h102, 32'h0, 32'h12345678, 1,  1'b0, 2,  32'h100, 4'hF, 32'h0, 32'h00001234);
    tbl[5]  = mk(OPC_LOAD,  F3_W,  32'h200, 32'h0, 32'h0,        99, 1'b1, 16, 32'h200, 4'hF, 32'h0, 32'h0);
    tbl[6]  = mk(OPC_LOAD,  3'b011, 32'h300, 32'h0, 32'h0,       0,  1'b1, 0,  32'h0, 4'h0, 32'h0, 32'h0);
    tbl[7]  = mk(OPC_STORE, F3_BU, 32'h300, 32'h1, 32'h0,        0,  1'b1, 0,  32'h0, 4'h0, 32'h0, 32'h0);
    tbl[8]  = mk(OPC_STORE, F3_B,  32'h003, 32'h0000005A, 32'h0, 0,  1'b0, 1,  32'h000, 4'h8, 32'h5A5A5A5A, 32'h0);
    tbl[9]  = mk(OPC_LOAD,  F3_H,  32'h402, 32'h0, 32'h80010000, 0,  1'b0, 1,  32'h400, 4'hF, 32'h0, 32'hFFFF8001);
    tbl[10] = mk(OPC_LOAD,  F3_W,  32'h040, 32'h0, 32'h11223344, 15, 1'b0, 16, 32'h040, 4'hF, 32'h0, 32'h11223344);
    tbl[11] = mk(OPC_LOAD,  F3_W,  32'h7FC, 32'h0, 32'h11223344, 16, 1'b1, 16, 32'h7FC, 4'hF, 32'h0, 32'h0);
`ifdef LSU_MISALIGNED_TRAP_EN
    tbl[12] = mk(OPC_LOAD,  F3_W,  32'h101, 32'h0, 32'hCAFEF00D, 0,  1'b1, 0,  32'h0, 4'h0, 32'h0, 32'h0);
    tbl[13] = mk(OPC_STORE, F3_H,  32'h103, 32'h00001234, 32'h0, 0,  1'b1, 0,  32'h0, 4'h0, 32'h0, 32'h0);
`else
    tbl[12] = mk(OPC_LOAD,  F3_W,  32'h101, 32'h0, 32'hCAFEF00D, 0,  1'b0, 1,  32'h100, 4'hF, 32'h0, 32'hCAFEF00D);
    tbl[13] = mk(OPC_STORE, F3_H,  32'h103, 32'h00001234, 32'h0, 0,  1'b0, 1,  32'h100, 4'hC, 32'h12341234, 32'h0);
`endif

    #1 rst = 1'b0;
    #1;
    chk("rst.req_ready", 32'(req_ready), 32'h1);
    chk("rst.stall", 32'(stall), 32'h0);
    chk("rst.resp_valid", 32'(resp_valid), 32'h0);
    chk("rst.resp_rdata", resp_rdata, 32'h0);
    chk("rst.resp_err", 32'(resp_err), 32'h0);
    chk("rst.mem_req", 32'(mem_req), 32'h0);
    chk("rst.mem_we", 32'(mem_we), 32'h0);
    chk("rst.mem_addr", mem_addr, 32'h0);
    chk("rst.mem_be", 32'(mem_be), 32'h0);
    chk("rst.mem_wdata", mem_wdata, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 14; i++) run_vec(tbl[i], $sformatf("vec%0d", i));

    // Reset in the middle of BUSY, then a stray ack that must be ignored.
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = F3_W; req_addr = 32'h500;
    @(negedge clk);
    req_valid = 1'b0;
    chk("mid.busy", 32'(mem_req), 32'h1);
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("mid.mem_req", 32'(mem_req), 32'h0);
    chk("mid.stall", 32'(stall), 32'h0);
    chk("mid.req_ready", 32'(req_ready), 32'h1);
    chk("mid.resp_valid", 32'(resp_valid), 32'h0);
    @(negedge clk);
    rst = 1'b1; mem_ack = 1'b1; mem_rdata = 32'h55AA55AA;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stray_ack.resp_valid", 32'(resp_valid), 32'h0);
      chk("stray_ack.mem_req", 32'(mem_req), 32'h0);
    end
    mem_ack = 1'b0;
    run_vec(tbl[0], "post_rst");

    for (int i = 0; i < 200; i++) begin
      v.opc     = ($urandom_range(0, 1) == 1) ? OPC_STORE : OPC_LOAD;
      v.f3      = 3'($urandom_range(0, 7));
      v.addr    = $urandom;
      v.wdata   = $urandom;
      v.rdata   = $urandom;
      v.ack_lat = ($urandom_range(0, 9) == 0) ? TMO + int'($urandom_range(0, 1)) - 1
                                               : int'($urandom_range(0, 3));
      v = model(v);
      run_vec(v, $sformatf("rand%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
